// File: rtl/sd_blk_arbiter.sv
// Round-robin arbiter sharing one SD block channel among NUM_DRV floppy drives.
// Optional ISSUE-phase ack timeout enabled by defining SD_ARB_TIMEOUT_EN.
module sd_blk_arbiter #(
  parameter int unsigned NUM_DRV        = 4,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NUM_DRV-1:0]     drv_rd,
  input  logic [NUM_DRV-1:0]     drv_wr,
  input  logic [NUM_DRV*32-1:0]  drv_lba,
  input  logic [NUM_DRV*8-1:0]   drv_buff_din,
  output logic [NUM_DRV-1:0]     drv_ack,
  output logic [NUM_DRV-1:0]     drv_buff_wr,
  output logic [31:0]            sd_lba,
  output logic                   sd_rd,
  output logic                   sd_wr,
  input  logic                   sd_ack,
  input  logic                   sd_buff_wr,
  output logic [7:0]             sd_buff_din,
  output logic [1:0]             grant,
  output logic                   busy,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, RELEASE} state_t;

  state_t      state, state_nx;
  logic [1:0]  rr_ptr, rr_ptr_nx, grant_nx;
  logic        sd_rd_nx, sd_wr_nx;
  logic [31:0] sd_lba_nx;
  logic [3:0]  pend4, wr4;
  logic [2:0]  scan_idx;
  logic [1:0]  sel;
  logic        sel_vld;
  logic [31:0] sel_lba;

`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0] to_cnt, to_cnt_nx;
  logic        timeout_err_nx;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_err    = 1'b0;
`endif

  assign busy = (state != IDLE);

  // Pad request vectors to the fixed 2-bit grant space so indexing stays width-clean.
  always_comb begin
    pend4 = '0;
    wr4   = '0;
    pend4[NUM_DRV-1:0] = drv_rd | drv_wr;
    wr4[NUM_DRV-1:0]   = drv_wr;
  end

  always_comb begin
    sel      = '0;
    sel_vld  = 1'b0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NUM_DRV; i++) begin
      scan_idx = {1'b0, rr_ptr} + 3'(i);
      if (scan_idx >= 3'(NUM_DRV)) scan_idx = scan_idx - 3'(NUM_DRV);
      if (!sel_vld && pend4[scan_idx[1:0]]) begin
        sel     = scan_idx[1:0];
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_lba     = '0;
    sd_buff_din = '0;
    drv_ack     = '0;
    drv_buff_wr = '0;
    for (int unsigned i = 0; i < NUM_DRV; i++) begin
      if (2'(i) == sel)   sel_lba     = drv_lba[i*32 +: 32];
      if (2'(i) == grant) sd_buff_din = drv_buff_din[i*8 +: 8];
      drv_ack[i]     = sd_ack & busy & (grant == 2'(i));
      drv_buff_wr[i] = sd_buff_wr & sd_ack & (grant == 2'(i));
    end
  end

  always_comb begin
    state_nx  = state;
    rr_ptr_nx = rr_ptr;
    grant_nx  = grant;
    sd_lba_nx = sd_lba;
    sd_rd_nx  = sd_rd;
    sd_wr_nx  = sd_wr;
`ifdef SD_ARB_TIMEOUT_EN
    to_cnt_nx      = to_cnt;
    timeout_err_nx = timeout_err;
`endif
    case (state)
      IDLE: begin
        if (sel_vld) begin
          grant_nx  = sel;
          sd_lba_nx = sel_lba;
          sd_wr_nx  = wr4[sel];
          sd_rd_nx  = ~wr4[sel];
          state_nx  = ISSUE;
`ifdef SD_ARB_TIMEOUT_EN
          to_cnt_nx = '0;
`endif
        end
      end
      ISSUE: begin
        if (sd_ack) begin
          sd_rd_nx = 1'b0;
          sd_wr_nx = 1'b0;
          state_nx = XFER;
        end else if (!pend4[grant]) begin
          sd_rd_nx = 1'b0;
          sd_wr_nx = 1'b0;
          state_nx = RELEASE;
        end
`ifdef SD_ARB_TIMEOUT_EN
        else if (to_cnt == TIMEOUT_CYCLES - 24'd1) begin
          sd_rd_nx       = 1'b0;
          sd_wr_nx       = 1'b0;
          timeout_err_nx = 1'b1;
          state_nx       = RELEASE;
        end else begin
          to_cnt_nx = to_cnt + 24'd1;
        end
`endif
      end
      XFER: begin
        if (!sd_ack) state_nx = RELEASE;
      end
      RELEASE: begin
        rr_ptr_nx = (grant == 2'(NUM_DRV - 1)) ? '0 : grant + 2'd1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      rr_ptr <= '0;
      grant  <= '0;
      sd_lba <= '0;
      sd_rd  <= 1'b0;
      sd_wr  <= 1'b0;
    end else begin
      state  <= state_nx;
      rr_ptr <= rr_ptr_nx;
      grant  <= grant_nx;
      sd_lba <= sd_lba_nx;
      sd_rd  <= sd_rd_nx;
      sd_wr  <= sd_wr_nx;
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt      <= to_cnt_nx;
      timeout_err <= timeout_err_nx;
    end
  end
`endif

endmodule

// File: tb/tb_sd_blk_arbiter.sv
// Bench for sd_blk_arbiter: directed scenarios plus randomized requests against a round-robin model.
module tb_sd_blk_arbiter;

  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [3:0]   drv_rd, drv_wr;
  logic [31:0]  lba [4];
  logic [7:0]   din [4];
  logic [127:0] drv_lba;
  logic [31:0]  drv_buff_din;
  logic [3:0]   drv_ack, drv_buff_wr;
  logic [31:0]  sd_lba;
  logic         sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [7:0]   sd_buff_din;
  logic [1:0]   grant;
  logic         busy, timeout_err;

  int checks = 0;
  int failures = 0;
  int exp_ptr = 0;

  assign drv_lba      = {lba[3], lba[2], lba[1], lba[0]};
  assign drv_buff_din = {din[3], din[2], din[1], din[0]};

  sd_blk_arbiter #(.NUM_DRV(4), .TIMEOUT_CYCLES(24'd100)) dut (
    .CLK(CLK), .RESET(RESET),
    .drv_rd(drv_rd), .drv_wr(drv_wr), .drv_lba(drv_lba), .drv_buff_din(drv_buff_din),
    .drv_ack(drv_ack), .drv_buff_wr(drv_buff_wr),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: first pending drive scanning from ptr, wrapping modulo N.
  function automatic int pick(input logic [3:0] p, input int ptr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (p[idx]) return idx;
    end
    return -1;
  endfunction

  // Called with DUT idle and requests just applied; runs one complete transfer.
  task automatic serve(input int g, input int dly, input int len, input int npulse, output int pulses);
    logic [3:0]  oh;
    logic        exp_w, exp_r;
    logic [31:0] exp_lba;
    oh      = 4'b0001 << g;
    exp_w   = drv_wr[g];
    exp_r   = drv_rd[g] & ~drv_wr[g];
    exp_lba = lba[g];
    pulses  = 0;
    tick(); #1;
    chk("grant", 32'(grant), 32'(g));
    chk("sd_lba", sd_lba, exp_lba);
    chk("sd_rd_issue", 32'(sd_rd), 32'(exp_r));
    chk("sd_wr_issue", 32'(sd_wr), 32'(exp_w));
    chk("busy_issue", 32'(busy), 32'd1);
    chk("drv_ack_issue", 32'(drv_ack), 32'd0);
    repeat (dly) begin
      tick(); #1;
      chk("sd_rd_hold", 32'(sd_rd), 32'(exp_r));
      chk("sd_wr_hold", 32'(sd_wr), 32'(exp_w));
    end
    sd_ack = 1'b1; #1;
    chk("drv_ack_rise", 32'(drv_ack), 32'(oh));
    tick();
    drv_rd[g] = 1'b0;
    drv_wr[g] = 1'b0;
    #1;
    chk("sd_rd_after_ack", 32'(sd_rd), 32'd0);
    chk("sd_wr_after_ack", 32'(sd_wr), 32'd0);
    for (int c = 0; c < len; c++) begin
      sd_buff_wr = (npulse < 0) ? 1'($urandom % 2) : (c < npulse);
      #1;
      chk("drv_ack_xfer", 32'(drv_ack), 32'(oh));
      chk("drv_buff_wr", 32'(drv_buff_wr), sd_buff_wr ? 32'(oh) : 32'd0);
      chk("sd_buff_din", 32'(sd_buff_din), 32'(din[g]));
      if (drv_buff_wr[g]) pulses++;
      tick();
    end
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    tick(); #1;
    chk("busy_release", 32'(busy), 32'd1);
    chk("drv_ack_release", 32'(drv_ack), 32'd0);
    tick(); #1;
    chk("busy_idle", 32'(busy), 32'd0);
    exp_ptr = (g + 1) % N;
  endtask

  initial begin
    int p, g;
    int seq [5] = '{0, 1, 2, 3, 0};
    RESET = 1'b1; drv_rd = '0; drv_wr = '0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
    for (int d = 0; d < N; d++) begin lba[d] = '0; din[d] = '0; end
    tick(); tick();
    chk("rst_sd_rd", 32'(sd_rd), 32'd0);
    chk("rst_sd_wr", 32'(sd_wr), 32'd0);
    chk("rst_sd_lba", sd_lba, 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    RESET = 1'b0;

    // Ack while idle is ignored.
    tick(); sd_ack = 1'b1; #1;
    chk("idle_ack_drv_ack", 32'(drv_ack), 32'd0);
    tick(); sd_ack = 1'b0; #1;
    chk("idle_ack_busy", 32'(busy), 32'd0);

    // Single read, 514-cycle ack with 512 buffer strobes.
    lba[0] = 32'h12; drv_rd = 4'b0001;
    serve(0, 0, 513, 512, p);
    chk("pulse_count", 32'(p), 32'd512);

    // Reset during XFER.
    drv_rd = 4'b0100; lba[2] = 32'hDEAD_0002;
    g = pick(drv_rd | drv_wr, exp_ptr);
    chk("model_pick_rst", 32'(g), 32'd2);
    tick(); #1;
    chk("grant_pre_rst", 32'(grant), 32'd2);
    sd_ack = 1'b1;
    tick();
    drv_rd = '0; RESET = 1'b1; #1;
    chk("rst_mid_sd_rd", 32'(sd_rd), 32'd0);
    chk("rst_mid_sd_wr", 32'(sd_wr), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_drv_ack", 32'(drv_ack), 32'd0);
    chk("rst_mid_grant", 32'(grant), 32'd0);
    sd_ack = 1'b0;
    tick(); RESET = 1'b0; exp_ptr = 0;
    lba[0] = 32'h0000_0777; drv_rd = 4'b0001;
    serve(0, 1, 4, -1, p);

    // Round robin with all drives requesting, from a fresh reset.
    RESET = 1'b1; tick(); RESET = 1'b0; exp_ptr = 0;
    for (int d = 0; d < N; d++) lba[d] = 32'h100 + 32'(d);
    drv_rd = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = pick(drv_rd | drv_wr, exp_ptr);
      chk("rr_order", 32'(g), 32'(seq[k]));
      serve(g, k % 3, 3, -1, p);
      drv_rd[g] = 1'b1;
    end
    drv_rd = '0;

    // Write on drive 1; buffer data comes from drive 1, not drive 0.
    drv_wr = 4'b0010; lba[1] = 32'h40; din[1] = 8'hA5; din[0] = 8'h3C;
    g = pick(drv_rd | drv_wr, exp_ptr);
    chk("model_pick_wr", 32'(g), 32'd1);
    serve(g, 2, 6, -1, p);
    chk("sd_buff_din_wr", 32'(sd_buff_din), 32'hA5);

    // Drive 2 abandons its request in ISSUE.
    drv_rd = 4'b0100;
    tick(); #1;
    chk("abort_sd_rd_issue", 32'(sd_rd), 32'd1);
    chk("abort_grant", 32'(grant), 32'd2);
    drv_rd = '0;
    tick(); #1;
    chk("abort_sd_rd_clear", 32'(sd_rd), 32'd0);
    chk("abort_busy_release", 32'(busy), 32'd1);
    chk("abort_drv_ack", 32'(drv_ack), 32'd0);
    tick(); #1;
    chk("abort_busy_idle", 32'(busy), 32'd0);
    exp_ptr = 3;
    drv_rd = 4'b1111;
    g = pick(drv_rd | drv_wr, exp_ptr);
    serve(g, 0, 2, -1, p);
    chk("abort_next_grant", 32'(g), 32'd3);
    drv_rd = '0;

    // Randomized requests against the round-robin model.
    for (int it = 0; it < 24; it++) begin
      for (int d = 0; d < N; d++) begin
        if (!(drv_rd[d] | drv_wr[d]) && ($urandom % 2 == 1)) begin
          lba[d] = $urandom;
          din[d] = 8'($urandom);
          case ($urandom % 3)
            0: drv_rd[d] = 1'b1;
            1: drv_wr[d] = 1'b1;
            default: begin drv_rd[d] = 1'b1; drv_wr[d] = 1'b1; end
          endcase
        end
      end
      if ((drv_rd | drv_wr) == 4'b0000) drv_rd[$urandom % 4] = 1'b1;
      g = pick(drv_rd | drv_wr, exp_ptr);
      serve(g, $urandom % 4, $urandom_range(20, 1), -1, p);
    end
    drv_rd = '0; drv_wr = '0;

`ifdef SD_ARB_TIMEOUT_EN
    begin
      int n;
      drv_rd = 4'b0001; lba[0] = 32'h55;
      g = pick(drv_rd | drv_wr, exp_ptr);
      n = 0;
      tick(); #1;
      while (sd_rd === 1'b1 && n < 200) begin
        n++;
        tick(); #1;
      end
      chk("timeout_issue_cycles", 32'(n), 32'd100);
      chk("timeout_err_set", 32'(timeout_err), 32'd1);
      chk("timeout_busy_release", 32'(busy), 32'd1);
      chk("timeout_drv_ack", 32'(drv_ack), 32'd0);
      drv_rd = '0;
      tick(); #1;
      chk("timeout_busy_idle", 32'(busy), 32'd0);
      exp_ptr = (g + 1) % N;
      drv_rd = 4'b0001;
      g = pick(drv_rd | drv_wr, exp_ptr);
      serve(g, 1, 3, -1, p);
      chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
    end
`else
    chk("timeout_err_off", 32'(timeout_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_blk_arbiter.md
Name: sd_blk_arbiter

Overview:
Shares one MiSTer SD block channel (lba/rd/wr/ack plus byte buffer) among NUM_DRV per-drive wd1793 requesters in the floppy subsystem. It grants one drive at a time using round-robin priority and holds the grant for the whole block transfer. It then steers ack, buffer write strobes and buffer read data between the granted drive and the host channel. It sits between the fdc drive instances and the hps_io SD port, so the core needs only one SD channel.

Parameters:
NUM_DRV, 4, number of requesting drives (2..4); grant index width fixed at 2 bits
TIMEOUT_CYCLES, 24'd5_000_000, cycles allowed from sd_rd/sd_wr assertion to first sd_ack (used only with optional feature)

Ports:
CLK  in  1  system clock; all state on rising edge
RESET  in  1  asynchronous, active-high reset
drv_rd  in  NUM_DRV  per-drive block read request, level, held until drv_ack
drv_wr  in  NUM_DRV  per-drive block write request, level, held until drv_ack
drv_lba  in  NUM_DRV x 32  per-drive block address
drv_buff_din  in  NUM_DRV x 8  per-drive buffer read data (write path to SD)
drv_ack  out  NUM_DRV  sd_ack routed to granted drive only
drv_buff_wr  out  NUM_DRV  sd_buff_wr routed to granted drive only
sd_lba  out  32  registered lba of granted drive
sd_rd  out  1  host block read request
sd_wr  out  1  host block write request
sd_ack  in  1  host acknowledge, high for entire transfer
sd_buff_wr  in  1  host buffer write strobe
sd_buff_din  out  8  drv_buff_din[grant], combinational
grant  out  2  index of current/last granted drive
busy  out  1  high in any state except IDLE
timeout_err  out  1  sticky error flag (optional feature only, else tied 0)

Behaviour:
- Reset (async): state=IDLE, sd_rd=sd_wr=0, sd_lba=0, grant=0, rr_ptr=0, busy=0, timeout_err=0.
- States: IDLE, ISSUE, XFER, RELEASE.
- IDLE: pending[i] = drv_rd[i] | drv_wr[i]. If any pending, select the first pending index scanning rr_ptr, rr_ptr+1, ... mod NUM_DRV. On the next edge: grant<=index, sd_lba<=drv_lba[index], sd_wr<=drv_wr[index], sd_rd<=drv_rd[index] & ~drv_wr[index] (write wins if both), state<=ISSUE. Latency from request to sd_rd/sd_wr is 1 cycle. sd_ack high in IDLE is ignored.
- ISSUE: if sd_ack=1, then sd_rd<=0, sd_wr<=0, state<=XFER. Else if the granted drive has dropped both requests, clear sd_rd/sd_wr and go to RELEASE (abort, no ack ever delivered).
- XFER: stay while sd_ack=1. When sd_ack=0, go to RELEASE.
- RELEASE: exactly 1 cycle; rr_ptr<=(grant+1) mod NUM_DRV; state<=IDLE. This guarantees the drive has dropped its request before re-arbitration.
- Routing is combinational on registered grant. drv_ack[i] = sd_ack & busy & (grant==i). drv_buff_wr[i] = sd_buff_wr & sd_ack & (grant==i). All non-granted bits are 0.
- sd_lba and grant hold their value outside transfers; no lba change while busy.
- A request arriving on another drive during a transfer waits. Maximum wait is (NUM_DRV-1) transfers (starvation-free).
- Indices >= NUM_DRV are never granted.

Optional Feature:
SD_ARB_TIMEOUT_EN. When defined, a 24-bit counter clears on ISSUE entry and increments each cycle in ISSUE. If it reaches TIMEOUT_CYCLES before sd_ack, the arbiter clears sd_rd/sd_wr, sets timeout_err=1 (sticky until RESET) and goes to RELEASE. The drive gets no ack and may re-request. When undefined, no counter exists, ISSUE waits forever and timeout_err is constant 0.

Test Plan:
- Reset mid-XFER (grant=2, sd_ack=1) -> same cycle: sd_rd=sd_wr=0, busy=0, drv_ack=0, grant=0; after release, a drv_rd=4'b0001 request is granted normally.
- drv_rd=4'b0001, drv_lba[0]=32'h12 -> 1 cycle later sd_rd=1, sd_lba=32'h12, grant=0. Host holds sd_ack for 514 cycles with 512 sd_buff_wr pulses -> drv_buff_wr[0] pulses 512 times, drv_buff_wr[3:1]=0, sd_rd drops the cycle after the ack rise, busy drops 2 cycles after the ack fall.
- drv_rd=4'b1111 held and re-raised after each ack -> grant sequence 0,1,2,3,0; drv_ack never has more than 1 bit set.
- drv_wr[1]=1, drv_lba[1]=32'h40, drv_buff_din[1]=8'hA5, drv_buff_din[0]=8'h3C -> sd_wr=1, sd_rd=0, sd_buff_din=8'hA5 throughout the transfer.
- Drive 2 drops its request in ISSUE before sd_ack -> sd_rd=0 next cycle, RELEASE then IDLE, drv_ack[2] never asserted, rr_ptr=3.
- With SD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, sd_ack held 0 -> sd_rd clears after 100 ISSUE cycles, timeout_err=1 and stays 1 across later good transfers.
